// File: rtl/subbytes_seq.sv
// Iterative AES SubBytes: LANES S-boxes sweep the 16-byte state over 16/LANES cycles.
// Forward and inverse S-boxes are computed algebraically (GF(2^8) inverse plus affine map).
module subbytes_seq #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [127:0] data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] sb,
    output logic         busy
);
    localparam int unsigned Groups = (LANES == 0) ? 16 : 16 / LANES;
    localparam int unsigned CntW = (Groups > 1) ? $clog2(Groups) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Groups - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : gen_bad_lanes
        $error("subbytes_seq: LANES must be one of 1, 2, 4, 8, 16");
    end

    typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [127:0]    work_q, work_d;
    logic            mode_q, mode_d;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    work_d  = data;
                    mode_d  = mode;
                    cnt_d   = '0;
                    state_d = StSub;
                end
            end
            StSub: begin
                // Byte k lives at bits [127-8k -: 8], so lane l of group cnt is byte cnt*LANES+l.
                for (int unsigned l = 0; l < LANES; l++) begin
                    work_d[8 * (15 - (32'(cnt_q) * LANES + l)) +: 8] =
                        mode_q ? sbox_inv(work_q[8 * (15 - (32'(cnt_q) * LANES + l)) +: 8])
                               : sbox_fwd(work_q[8 * (15 - (32'(cnt_q) * LANES + l)) +: 8]);
                end
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            work_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign sb        = work_q;

endmodule

// File: tb/tb_subbytes_seq.sv
// Bench for subbytes_seq: one instance per legal LANES value, table-based reference model,
// expected results queued at stimulus time and compared when the selected instance completes.
module tb_subbytes_seq;
    localparam int NInst = 5;

    logic         clk;
    logic         rst;
    logic         in_valid  [NInst];
    logic         in_ready  [NInst];
    logic         mode      [NInst];
    logic [127:0] data      [NInst];
    logic         out_valid [NInst];
    logic         out_ready [NInst];
    logic [127:0] sb        [NInst];
    logic         busy      [NInst];

    for (genvar g = 0; g < NInst; g++) begin : gen_dut
        subbytes_seq #(.LANES(1 << g)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .mode     (mode[g]),
            .data     (data[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .sb       (sb[g]),
            .busy     (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           sel      = 0;
    logic [127:0] exp_fifo [$];
    logic [127:0] sbox_rows [16];
    logic [7:0]   fwd_tab [256];
    logic [7:0]   inv_tab [256];

    localparam logic [127:0] Pt = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] Ct = 128'h638293c31bfc33f5c4eeacea4bc12816;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic m);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            b = d[8 * (15 - k) +: 8];
            r[8 * (15 - k) +: 8] = m ? inv_tab[b] : fwd_tab[b];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid[sel] === 1'b1 && out_ready[sel] === 1'b1) begin
            if (exp_fifo.size() == 0) check_val("spurious_out", 128'd1, 128'd0);
            else check_val("sb", sb[sel], exp_fifo.pop_front());
        end
    end

    task automatic wait_done(input int idx, input string tag);
        int n = 0;
        while (out_valid[idx] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_val({tag, "_latency"}, 128'(n), 128'(16 >> idx));
    endtask

    // Caller is at posedge+1 with the instance idle and its out_ready high.
    task automatic run_block(input int idx, input logic [127:0] d, input logic m,
                             input logic [127:0] exp, input string tag);
        sel = idx;
        exp_fifo.push_back(exp);
        in_valid[idx] = 1'b1;
        data[idx]     = d;
        mode[idx]     = m;
        @(posedge clk); #1;
        in_valid[idx] = 1'b0;
        wait_done(idx, tag);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_fifo.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("drain", 128'(exp_fifo.size()), 128'd0);
    endtask

    task automatic stream(input int idx, input int nblk);
        int           last, cyc, got, gap;
        logic [127:0] d;
        logic         m;
        gap  = (16 >> idx) + 2;
        sel  = idx;
        last = -1;
        cyc  = 0;
        got  = 0;
        d = {$urandom, $urandom, $urandom, $urandom};
        m = 1'($urandom);
        in_valid[idx] = 1'b1;
        data[idx]     = d;
        mode[idx]     = m;
        while (got < nblk && cyc < 400) begin
            if (in_ready[idx] === 1'b1) begin
                exp_fifo.push_back(ref_sub(d, m));
                if (last >= 0) check_val("b2b_gap", 128'(cyc - last), 128'(gap));
                last = cyc;
                got++;
                @(posedge clk); #1;
                cyc++;
                d = {$urandom, $urandom, $urandom, $urandom};
                m = 1'($urandom);
                data[idx] = d;
                mode[idx] = m;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        in_valid[idx] = 1'b0;
        check_val("b2b_count", 128'(got), 128'(nblk));
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d2, e2;
        int           seen;

        sbox_rows = '{
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
        };
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) fwd_tab[16 * i + j] = sbox_rows[i][8 * (15 - j) +: 8];
        end
        for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

        for (int g = 0; g < NInst; g++) begin
            in_valid[g]  = 1'b0;
            mode[g]      = 1'b0;
            data[g]      = '0;
            out_ready[g] = 1'b1;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int g = 0; g < NInst; g++) begin
            check_val("rst_out_valid", 128'(out_valid[g]), 128'd0);
            check_val("rst_busy", 128'(busy[g]), 128'd0);
            check_val("rst_in_ready", 128'(in_ready[g]), 128'd1);
            check_val("rst_sb", sb[g], 128'd0);
        end

        // Known-answer vectors: forward at LANES=4, inverse at every width.
        run_block(2, Pt, 1'b0, Ct, "fwd_l4");
        for (int g = 0; g < NInst; g++) run_block(g, Ct, 1'b1, Pt, "inv");

        // Consumer stall in DONE while a second block is offered.
        sel = 2;
        out_ready[2] = 1'b0;
        exp_fifo.push_back(Ct);
        in_valid[2] = 1'b1;
        data[2]     = Pt;
        mode[2]     = 1'b0;
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        wait_done(2, "stall");
        d2 = {$urandom, $urandom, $urandom, $urandom};
        e2 = ref_sub(d2, 1'b0);
        in_valid[2] = 1'b1;
        data[2]     = d2;
        for (int i = 0; i < 10; i++) begin
            check_val("stall_sb", sb[2], Ct);
            check_val("stall_in_ready", 128'(in_ready[2]), 128'd0);
            check_val("stall_out_valid", 128'(out_valid[2]), 128'd1);
            @(posedge clk); #1;
        end
        exp_fifo.push_back(e2);
        out_ready[2] = 1'b1;
        @(posedge clk); #1;
        check_val("stall_release_ready", 128'(in_ready[2]), 128'd1);
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        wait_done(2, "second");
        @(posedge clk); #1;

        // Reset in the second SUB cycle at LANES=1 aborts without a result.
        sel = 0;
        in_valid[0] = 1'b1;
        data[0]     = {$urandom, $urandom, $urandom, $urandom};
        mode[0]     = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("abort_busy", 128'(busy[0]), 128'd0);
        check_val("abort_sb", sb[0], 128'd0);
        check_val("abort_in_ready", 128'(in_ready[0]), 128'd1);
        check_val("abort_out_valid", 128'(out_valid[0]), 128'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid[0] !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        check_val("abort_no_pulse", 128'(seen), 128'd0);
        run_block(0, 128'd0, 1'b0, {16{8'h63}}, "after_abort");

        // Mode changes after acceptance must not affect the block in flight.
        sel = 2;
        exp_fifo.push_back({16{8'hed}});
        in_valid[2] = 1'b1;
        data[2]     = {16{8'h53}};
        mode[2]     = 1'b0;
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        for (int i = 0; i < 40 && out_valid[2] !== 1'b1; i++) begin
            mode[2] = ~mode[2];
            @(posedge clk); #1;
        end
        check_val("mode_toggle_done", 128'(out_valid[2]), 128'd1);
        @(posedge clk); #1;
        mode[2] = 1'b0;

        for (int g = 0; g < NInst; g++) stream(g, 8);

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/subbytes_seq.md
SUBBYTES_SEQ -- requirements
Module: subbytes_seq

Interface
REQ-001 The block SHALL have one parameter: LANES, default 4, number of S-box lanes applied per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port in_valid, input, 1: data and mode are valid this cycle.
REQ-005 Port in_ready, output, 1: the block accepts a new state this cycle.
REQ-006 Port mode, input, 1: substitution mode; 0 = forward S-box (encrypt), 1 = inverse S-box (decrypt).
REQ-007 Port data, input, 128: input state; byte 0 = data[127:120], byte 15 = data[7:0].
REQ-008 Port out_valid, output, 1: sb holds a completed result.
REQ-009 Port out_ready, input, 1: the consumer accepts sb this cycle.
REQ-010 Port sb, output, 128: substituted state, with the same byte order as data.
REQ-011 Port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-012 A LANES value not in {1,2,4,8,16} SHALL fail elaboration.
REQ-013 The FSM SHALL have three states: IDLE, SUB and DONE.
REQ-014 In IDLE: in_ready=1; a cycle with in_valid=1 SHALL capture data into the working register, latch mode, clear the byte counter and move to SUB.
REQ-015 In SUB and DONE: in_ready=0; in_valid and data SHALL be ignored.
REQ-016 In SUB, each cycle SHALL replace bytes cnt*LANES .. cnt*LANES+LANES-1 of the working register with S(byte) or InvS(byte), per the latched mode.
REQ-017 The forward and inverse tables SHALL match FIPS-197.
REQ-018 The counter SHALL be ceil(log2(16/LANES)) bits wide, minimum 1, and SHALL increment once per SUB cycle.
REQ-019 After the cycle that processes the last group (cnt = 16/LANES-1), the FSM SHALL move to DONE; the counter SHALL NOT wrap into a further SUB cycle.
REQ-020 Latency: accept on edge T SHALL give out_valid=1 after edge T+16/LANES.
REQ-021 LANES=16 SHALL give one SUB cycle.
REQ-022 In DONE: out_valid=1 and sb equals the working register; sb SHALL stay stable until out_ready=1.
REQ-023 out_ready=1 in DONE SHALL complete the output handshake and return the FSM to IDLE on the next edge.
REQ-024 out_ready held low SHALL stall the block in DONE indefinitely, with no loss of data.
REQ-025 out_valid SHALL be 0 in IDLE and SUB; sb is don't-care there but SHALL NOT take X after reset.
REQ-026 Maximum throughput SHALL be one block per 16/LANES+2 cycles (accept, SUB cycles, DONE).
REQ-027 A change of mode after acceptance SHALL have no effect on the block in flight.
REQ-028 The block SHALL hold only one state in flight; there is no input buffering.

Reset
REQ-029 rst=1 SHALL, on the next edge, force: FSM=IDLE, counter=0, working register=0, latched mode=0.
REQ-030 Outputs after reset SHALL be: out_valid=0, busy=0, in_ready=1, sb=128'h0.
REQ-031 rst SHALL take priority over every other input, including in_valid and out_ready in the same cycle.
REQ-032 Reset during SUB or DONE SHALL abort the operation, discard the partial result and produce no out_valid pulse.

Verification
REQ-033 LANES=4, mode=0, data=128'h00112233445566778899aabbccddeeff -> out_valid after 4 cycles, sb=128'h638293c31bfc33f5c4eeacea4bc12816.
REQ-034 mode=1, data=128'h638293c31bfc33f5c4eeacea4bc12816 -> sb=128'h00112233445566778899aabbccddeeff; SHALL be repeated for LANES = 1, 2, 8, 16 with latency 16, 8, 2, 1.
REQ-035 out_ready held 0 for 10 cycles in DONE while in_valid=1 with new data -> sb unchanged, in_ready=0, second block not accepted until after the handshake.
REQ-036 rst=1 asserted in the 2nd SUB cycle with LANES=1 -> next cycle busy=0, sb=0, in_ready=1, no out_valid; a new block with data=0 and mode=0 -> sb=128'h6363...63 (all 16 bytes 0x63).
REQ-037 mode toggled during SUB for data = all bytes 0x53, mode=0 -> sb = all bytes 0xED.
REQ-038 Back-to-back blocks with out_ready tied to 1 -> in_ready pulses once every 16/LANES+2 cycles, and every result matches a reference-model check.
